// File: rtl/ahb_master.sv
// AHB-Lite initiator: one NONSEQ single transfer per command from a valid/ready port.
// Define AHB_MASTER_TIMEOUT_EN to abort transfers stalled by HREADY=0 for TIMEOUT_CYCLES cycles.
module ahb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERRC = 2'd3} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  state_t      state_q, state_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] haddr_d, hwdata_d, rsp_rdata_d;
  logic [1:0]  htrans_d;
  logic [2:0]  hsize_d;
  logic        hwrite_d, rsp_valid_d, rsp_err_d;
  logic        misaligned_c;

  assign cmd_ready    = (state_q == IDLE);
  assign misaligned_c = (cmd_size > 3'd2) ||
                        ((cmd_size == 3'd1) && cmd_addr[0]) ||
                        ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          stall_c;
  assign stall_c = ((state_q == ADDR) || (state_q == DATA)) && !HREADY;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    haddr_d     = HADDR;
    htrans_d    = HTRANS;
    hwrite_d    = HWRITE;
    hsize_d     = HSIZE;
    hwdata_d    = HWDATA;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
`ifdef AHB_MASTER_TIMEOUT_EN
    tmo_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (misaligned_c) begin
            state_d     = ERRC;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = ADDR;
            htrans_d = TRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            wdata_d  = cmd_wdata;
          end
        end
      end
      ADDR: begin
        if (HREADY) begin
          state_d  = DATA;
          htrans_d = TRANS_IDLE;
          if (HWRITE) hwdata_d = wdata_q;
        end
      end
      DATA: begin
        // RETRY and SPLIT are reported as errors rather than reissued.
        if (HREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (HRESP != RESP_OKAY);
          if (!HWRITE && (HRESP == RESP_OKAY)) rsp_rdata_d = HRDATA;
        end
      end
      ERRC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AHB_MASTER_TIMEOUT_EN
    if (stall_c) begin
      if (tmo_q == TMO_LAST) begin
        state_d     = IDLE;
        htrans_d    = TRANS_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end else begin
        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      wdata_q   <= '0;
      HADDR     <= '0;
      HTRANS    <= TRANS_IDLE;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      HADDR     <= haddr_d;
      HTRANS    <= htrans_d;
      HWRITE    <= hwrite_d;
      HSIZE     <= hsize_d;
      HWDATA    <= hwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

`ifdef AHB_MASTER_TIMEOUT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: a transaction-level timeline model predicts every output per cycle.
module tb_ahb_master;
  localparam int MAXC = 1500;
  localparam int TMO  = 16;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE;

  ahb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata;
    int a; int d; logic [1:0] resp; logic [31:0] rdata; bit hold; int gap;
  } cmd_t;

  // per-cycle stimulus
  logic        in_valid [MAXC]; logic in_write [MAXC]; logic [31:0] in_addr [MAXC];
  logic [2:0]  in_size [MAXC];  logic [31:0] in_wdata [MAXC];
  logic        in_hready [MAXC]; logic [1:0] in_hresp [MAXC]; logic [31:0] in_hrdata [MAXC];
  // per-cycle expectations
  logic        x_ready [MAXC]; logic [1:0] x_htrans [MAXC]; logic [31:0] x_haddr [MAXC];
  logic        x_hwrite [MAXC]; logic [2:0] x_hsize [MAXC];
  logic        x_wphase [MAXC]; logic [31:0] x_hwdata [MAXC];
  logic        x_rsp [MAXC]; logic x_err [MAXC]; logic x_upd [MAXC];
  logic [31:0] x_upd_val [MAXC]; logic [31:0] x_rdata [MAXC];
  // recorded DUT outputs, for the literal pins
  logic        r_rsp [MAXC]; logic r_err [MAXC]; logic [31:0] r_rdata [MAXC];
  logic [1:0]  r_htrans [MAXC]; logic [31:0] r_haddr [MAXC]; logic [31:0] r_hwdata [MAXC];

  int total = 0, bad = 0;
  int cyc = 0, ncyc = 0;
  bit run_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic cmd_t mk(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                              int a, int d, logic [1:0] resp, logic [31:0] rdata, bit hold, int gap);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.size = size; c.wdata = wdata; c.a = a; c.d = d;
    c.resp = resp; c.rdata = rdata; c.hold = hold; c.gap = gap;
    return c;
  endfunction

  function automatic cmd_t pick(int i);
    cmd_t c;
    case (i)
      0: c = mk(1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0, 2'b00, 32'h0, 0, 0);
      1: c = mk(0, 32'h10, 3'd2, 32'h0, 0, 2, 2'b00, 32'hDEADBEEF, 0, 0);
      2: c = mk(0, 32'h2, 3'd2, 32'h0, 0, 0, 2'b00, 32'h0, 0, 0);
      3: c = mk(0, 32'h20, 3'd2, 32'h0, 0, 1, 2'b01, 32'h12345678, 0, 0);
      4: c = mk(1, 32'h100, 3'd2, 32'h11111111, 0, 0, 2'b00, 32'h0, 1, 0);
      5: c = mk(0, 32'h104, 3'd1, 32'h0, 0, 0, 2'b00, 32'hCAFE0000, 1, 0);
      6: c = mk(1, 32'h3, 3'd0, 32'h000000AB, 0, 0, 2'b00, 32'h0, 1, 0);
`ifdef AHB_MASTER_TIMEOUT_EN
      7: c = mk(0, 32'h40, 3'd2, 32'h0, 0, 20, 2'b00, 32'h0, 0, 1);
`endif
      default: begin
        c.wr    = 1'($urandom);
        c.size  = ($urandom % 8 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
        c.addr  = $urandom;
        if ($urandom % 4 != 0) begin
          if (c.size == 3'd1) c.addr[0] = 1'b0;
          if (c.size == 3'd2) c.addr[1:0] = 2'b00;
        end
        c.wdata = $urandom;
        c.a     = int'($urandom % 3);
        c.d     = int'($urandom % 4);
        c.resp  = ($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        c.rdata = $urandom;
        c.hold  = 1'($urandom);
        c.gap   = int'($urandom % 3);
      end
    endcase
    return c;
  endfunction

  // Lay each command onto a cycle timeline: accept edge e, a address waits, d data waits.
  task automatic build_model();
    int free, prev_s, i, s, lo, e, r, nd, t;
    bit mis, tmo;
    cmd_t c;
    logic [31:0] cur;
    free = 0; prev_s = -1; i = 0;
    for (int k = 0; k < MAXC; k++) begin
      in_valid[k] = 1'b0; in_write[k] = 1'($urandom); in_addr[k] = $urandom;
      in_size[k] = 3'($urandom); in_wdata[k] = $urandom;
      in_hready[k] = 1'($urandom); in_hresp[k] = 2'($urandom); in_hrdata[k] = $urandom;
      x_ready[k] = 1'b1; x_htrans[k] = 2'b00; x_haddr[k] = '0; x_hwrite[k] = 1'b0; x_hsize[k] = '0;
      x_wphase[k] = 1'b0; x_hwdata[k] = '0; x_rsp[k] = 1'b0; x_err[k] = 1'b0;
      x_upd[k] = 1'b0; x_upd_val[k] = '0; x_rdata[k] = '0;
    end
    while (free < MAXC - 60) begin
      c  = pick(i);
      s  = c.hold ? free : free + c.gap;
      lo = c.hold ? prev_s + 1 : s;
      for (int k = lo; k <= s; k++) begin
        in_valid[k] = 1'b1; in_write[k] = c.wr; in_addr[k] = c.addr;
        in_size[k] = c.size; in_wdata[k] = c.wdata;
      end
      e   = s + 1;
      mis = (c.size > 3'd2) || (c.size == 3'd1 && c.addr[0]) || (c.size == 3'd2 && c.addr[1:0] != 2'b00);
      if (mis) begin
        x_rsp[e] = 1'b1; x_err[e] = 1'b1; x_ready[e] = 1'b0;
        free = e + 1;
      end else begin
        for (int k = e; k <= e + c.a; k++) begin
          x_htrans[k] = 2'b10; x_haddr[k] = c.addr; x_hwrite[k] = c.wr; x_hsize[k] = c.size;
          in_hready[k] = (k == e + c.a); in_hresp[k] = 2'b00; x_ready[k] = 1'b0;
        end
`ifdef AHB_MASTER_TIMEOUT_EN
        tmo = (c.d >= TMO);
`else
        tmo = 1'b0;
`endif
        nd = tmo ? TMO : c.d + 1;
        for (int j = 0; j < nd; j++) begin
          t = e + c.a + 1 + j;
          in_hready[t] = !tmo && (j == c.d);
          in_hresp[t]  = (c.resp != 2'b00 && j >= c.d - 1) ? c.resp : 2'b00;
          if (j == c.d) in_hrdata[t] = c.rdata;
          x_wphase[t] = c.wr; x_hwdata[t] = c.wdata; x_ready[t] = 1'b0;
        end
        r = e + c.a + 1 + nd;
        x_rsp[r] = 1'b1;
        x_err[r] = tmo || (c.resp != 2'b00);
        if (!c.wr && c.resp == 2'b00 && !tmo) begin
          x_upd[r] = 1'b1; x_upd_val[r] = c.rdata;
        end
        free = r;
      end
      prev_s = s; i++;
    end
    ncyc = free + 3;
    cur = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (x_upd[k]) cur = x_upd_val[k];
      x_rdata[k] = cur;
    end
  endtask

  // Single compare process: DUT outputs against the timeline, mid-cycle.
  initial forever begin
    @(negedge HCLK);
    if (run_active) begin
      r_rsp[cyc] = rsp_valid; r_err[cyc] = rsp_err; r_rdata[cyc] = rsp_rdata;
      r_htrans[cyc] = HTRANS; r_haddr[cyc] = HADDR; r_hwdata[cyc] = HWDATA;
      chk("cmd_ready", 32'(cmd_ready), 32'(x_ready[cyc]));
      chk("htrans", 32'(HTRANS), 32'(x_htrans[cyc]));
      if (x_htrans[cyc] == 2'b10) begin
        chk("haddr", HADDR, x_haddr[cyc]);
        chk("hwrite", 32'(HWRITE), 32'(x_hwrite[cyc]));
        chk("hsize", 32'(HSIZE), 32'(x_hsize[cyc]));
      end
      if (x_wphase[cyc]) chk("hwdata", HWDATA, x_hwdata[cyc]);
      chk("rsp_valid", 32'(rsp_valid), 32'(x_rsp[cyc]));
      if (x_rsp[cyc]) chk("rsp_err", 32'(rsp_err), 32'(x_err[cyc]));
      chk("rsp_rdata", rsp_rdata, x_rdata[cyc]);
    end
  end

  initial begin
    HRESETn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; HREADY = 1'b1; HRDATA = '0; HRESP = 2'b00;
    build_model();
    #2 HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hctl", {28'd0, HWRITE, HSIZE}, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    HRESETn = 1'b1;

    run_active = 1'b1;
    for (int t = 0; t < ncyc; t++) begin
      cyc = t;
      cmd_valid = in_valid[t]; cmd_write = in_write[t]; cmd_addr = in_addr[t];
      cmd_size = in_size[t]; cmd_wdata = in_wdata[t];
      HREADY = in_hready[t]; HRESP = in_hresp[t]; HRDATA = in_hrdata[t];
      @(posedge HCLK); #1;
    end
    run_active = 1'b0;
    cmd_valid = 1'b0;

    // hand-derived pins for the opening directed commands
    chk("pin_wr_nonseq", {30'd0, r_htrans[1]}, 32'd2);
    chk("pin_wr_haddr", r_haddr[1], 32'h10);
    chk("pin_wr_hwdata", r_hwdata[2], 32'hDEADBEEF);
    chk("pin_wr_rsp", {30'd0, r_rsp[3], r_err[3]}, 32'b10);
    chk("pin_rd_rsp", {30'd0, r_rsp[8], r_err[8]}, 32'b10);
    chk("pin_rd_data", r_rdata[8], 32'hDEADBEEF);
    chk("pin_mis_rsp", {30'd0, r_rsp[9], r_err[9]}, 32'b11);
    chk("pin_mis_htrans", {30'd0, r_htrans[9]}, 32'd0);
    chk("pin_err_rsp", {30'd0, r_rsp[14], r_err[14]}, 32'b11);
    chk("pin_err_rdata", r_rdata[14], 32'hDEADBEEF);
    chk("pin_b2b_ns", {26'd0, r_htrans[15], r_htrans[18], r_htrans[21]}, {26'd0, 6'b101010});
    chk("pin_b2b_rsp", {30'd0, r_rsp[17], r_rsp[20]}, 32'b11);
    chk("pin_b2b_rdata", r_rdata[20], 32'hCAFE0000);
`ifdef AHB_MASTER_TIMEOUT_EN
    chk("pin_tmo_rsp", {30'd0, r_rsp[42], r_err[42]}, 32'b11);
    chk("pin_tmo_early", 32'(r_rsp[41]), 32'd0);
`endif

    // reset asserted while a read waits in its data phase
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_size = 3'd2; HREADY = 1'b1; HRESP = 2'b00;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    chk("rst_mid_nonseq", 32'(HTRANS), 32'd2);
    @(posedge HCLK); #1;
    HREADY = 1'b0;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_htrans", 32'(HTRANS), 32'd0);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_mid_haddr", HADDR, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1; HREADY = 1'b1;
    chk("rst_rel_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("rst_no_rsp", {30'd0, rsp_valid, HTRANS != 2'b00}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
